// File: rtl/demux_deserializer.sv
// Receive side of the 4:1 selector link: rebuilds a 4-bit word from four serial
// lane bits (MSB first), one-hot checks it and hands it out on a valid/ready port.
module demux_deserializer #(
    parameter int unsigned TIMEOUT    = 16,
    parameter bit          STICKY_ERR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic       in_valid,
    input  logic       sync,
    output logic [3:0] out,
    output logic [1:0] index,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       error,
    output logic       overrun,
    output logic       frame_abort,
    output logic       busy
);

    localparam int unsigned WORD_W = 4;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned IDLE_W = 8;

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } state_t;

    state_t              state, state_n;
    logic [LANE_W-1:0]   lane, lane_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_n, idle_inc;
    logic [WORD_W-1:1]   shreg, shreg_n;
    logic [WORD_W-1:0]   out_n;
    logic [LANE_W-1:0]   index_n;
    logic                out_valid_n;
    logic                error_n;
    logic                overrun_n;
    logic                frame_abort_n;

    logic [WORD_W-1:0]   word_c;
    logic                onehot_c;
    logic [LANE_W-1:0]   enc_c;

    // The lane-3 bit is taken straight from the input so the word completes on its own edge.
    assign word_c   = {shreg, in};
    assign idle_inc = idle_cnt + IDLE_W'(1);

    // One-hot check and lane encoding of the word being completed.
    always_comb begin
        onehot_c = 1'b0;
        enc_c    = 2'b00;
        case (word_c)
            4'b1000: begin onehot_c = 1'b1; enc_c = 2'b00; end
            4'b0100: begin onehot_c = 1'b1; enc_c = 2'b01; end
            4'b0010: begin onehot_c = 1'b1; enc_c = 2'b10; end
            4'b0001: begin onehot_c = 1'b1; enc_c = 2'b11; end
            default: begin onehot_c = 1'b0; enc_c = 2'b00; end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lane        <= '0;
            idle_cnt    <= '0;
            shreg       <= '0;
            out         <= '0;
            index       <= '0;
            out_valid   <= 1'b0;
            error       <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            lane        <= lane_n;
            idle_cnt    <= idle_n;
            shreg       <= shreg_n;
            out         <= out_n;
            index       <= index_n;
            out_valid   <= out_valid_n;
            error       <= error_n;
            overrun     <= overrun_n;
            frame_abort <= frame_abort_n;
            busy        <= (state_n == COLLECT);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        lane_n        = lane;
        idle_n        = idle_cnt;
        shreg_n       = shreg;
        out_n         = out;
        index_n       = index;
        out_valid_n   = out_valid & ~out_ready;
        error_n       = error;
        overrun_n     = 1'b0;
        frame_abort_n = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && sync) begin
                    shreg_n = {in, 2'b00};
                    lane_n  = LANE_W'(1);
                    idle_n  = '0;
                    state_n = COLLECT;
                end
            end

            COLLECT: begin
                if (in_valid && sync) begin
                    frame_abort_n = 1'b1;
                    shreg_n       = {in, 2'b00};
                    lane_n        = LANE_W'(1);
                    idle_n        = '0;
                end else if (in_valid) begin
                    idle_n = '0;
                    if (lane == LANE_W'(3)) begin
                        out_n       = word_c;
                        index_n     = enc_c;
                        out_valid_n = 1'b1;
                        overrun_n   = out_valid & ~out_ready;
                        if (!onehot_c) begin
                            error_n = 1'b1;
                        end else if (!STICKY_ERR) begin
                            error_n = 1'b0;
                        end
                        lane_n  = '0;
                        state_n = IDLE;
                    end else begin
                        case (lane)
                            2'd1:    shreg_n[2] = in;
                            2'd2:    shreg_n[1] = in;
                            default: shreg_n    = shreg;
                        endcase
                        lane_n = lane + LANE_W'(1);
                    end
                end else begin
                    // Idle gap inside a frame; give up on the frame once the budget runs out.
                    if (idle_inc >= IDLE_W'(TIMEOUT)) begin
                        frame_abort_n = 1'b1;
                        lane_n        = '0;
                        idle_n        = '0;
                        state_n       = IDLE;
                    end else begin
                        idle_n = idle_inc;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                lane_n  = '0;
                idle_n  = '0;
            end
        endcase
    end

endmodule
